lcd_controller: RTL
===================

Name: lcd_controller

Overview:
- Downstream consumer of the core's LCD output path: the LSU-decoded LCD request (register select plus 8-bit data/command) enters here, and the block generates HD44780-compatible bus timing for the 16x2 character LCD.
- Runs the power-on initialisation sequence on its own, then serialises software requests with correct setup, enable-pulse, hold and execution delays.
- Software polls o_busy/o_init_done, which the LSU maps into the LCD read-back word.

Parameters:
- T_PWRON, 750000, cycles to wait after reset before the first init command (15 ms @ 50 MHz).
- T_SETUP, 4, cycles RS/DATA are stable before EN rises.
- T_EN, 12, cycles EN stays high.
- T_HOLD, 2, cycles RS/DATA are held after EN falls.
- T_EXEC, 2000, post-pulse wait for normal commands and data writes (40 us).
- T_CLEAR, 82000, post-pulse wait for clear-display / return-home (1.64 ms).
- CNT_W, 20, delay counter width; must hold max(all T_*). Every T_* must be ≥1.

Ports:
- i_clk, in, 1, system clock.
- i_reset, in, 1, synchronous active-high reset.
- i_req_vld, in, 1, request valid.
- i_req_rs, in, 1, 0 = command, 1 = character data.
- i_req_data, in, 8, command/data byte.
- o_req_rdy, out, 1, request accepted when i_req_vld & o_req_rdy.
- o_busy, out, 1, a transfer, delay or init is in progress.
- o_init_done, out, 1, sticky; set when the init sequence completes.
- o_lcd_on, out, 1, LCD power/backlight enable.
- o_lcd_en, out, 1, LCD EN strobe.
- o_lcd_rs, out, 1, LCD RS.
- o_lcd_rw, out, 1, LCD RW; tied 0 (write-only).
- o_lcd_data, out, 8, LCD DB[7:0].

Behaviour:
- Clock/reset: one clock i_clk. Reset i_reset is synchronous, active-high, and acts at the next edge, including mid-transfer.
- Reset values: state=PWR_WAIT, counter=0, init index=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0x00, o_lcd_on=0, o_init_done=0, o_req_rdy=0, o_busy=1.
- o_lcd_on=1 from the first cycle after reset deasserts.
- States: PWR_WAIT, INIT_LOAD, SETUP, EN_HI, HOLD, EXEC_WAIT, IDLE.
- PWR_WAIT: count T_PWRON cycles -> INIT_LOAD.
- INIT_LOAD: load init ROM entry [idx] (rs=0). The ROM is 0x38, 0x0C, 0x01, 0x06 -> SETUP.
- SETUP: drive rs/data, EN=0, for T_SETUP cycles -> EN_HI.
- EN_HI: EN=1 for T_EN cycles -> HOLD.
- HOLD: EN=0, rs/data unchanged, for T_HOLD cycles -> EXEC_WAIT.
- EXEC_WAIT: wait T_CLEAR if the latched byte is a long command, else T_EXEC.
  - Long command: rs=0 and data is 0x01, 0x02 or 0x03.
  - Exit: if init is active and idx<3, idx++ -> INIT_LOAD. If idx==3, set o_init_done and go IDLE. Otherwise go IDLE.
- IDLE: o_req_rdy=1, o_busy=0. On i_req_vld the rs/data are latched at that edge -> SETUP the next cycle.
- Request latency: accept edge to EN rise = T_SETUP+1 cycles. Busy span = T_SETUP+T_EN+T_HOLD+T_wait cycles, then IDLE.
- Outside IDLE: o_req_rdy=0. i_req_vld is ignored, with no capture and no loss of the in-flight request.
- Registered outputs: o_lcd_rs/o_lcd_data change only on entry to SETUP and are otherwise stable. EN is never high outside EN_HI.
- Counter: counts 0..T_x-1 per state and clears on every state change. No wrap-around beyond the terminal count.
- Reset mid-operation: EN drops at that edge, o_init_done clears, and the full init sequence replays.

Optional Feature:
- Macro: LCD_REQ_FIFO_EN.
- Defined: a 4-entry FIFO of {rs,data[7:0]} sits in front of the FSM.
  - o_req_rdy = !fifo_full, in every state including init; requests queue during init.
  - IDLE pops when the FIFO is non-empty.
  - o_busy = (state!=IDLE) | !fifo_empty.
  - Simultaneous push and pop when full is not allowed (rdy=0). Simultaneous push and pop otherwise keeps the count unchanged.
  - Reset empties the FIFO.
- Undefined: single-request behaviour exactly as above.

Test Plan:
- Bench parameters for all cases: T_PWRON=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_EXEC=5, T_CLEAR=20.
- Reset release -> o_busy=1, EN=0 for 10 cycles. Four EN pulses, each 3 cycles wide, with data 0x38, 0x0C, 0x01, 0x06 and rs=0. Gap after 0x01 is 20 cycles, others 5. Then o_init_done=1, o_req_rdy=1.
- After init, send rs=1, data=0x41 -> EN rises 3 cycles after the accept edge and stays high 3 cycles. rs=1 and data=0x41 hold from SETUP through HOLD. IDLE returns 11 cycles after SETUP entry.
- Send rs=0, data=0x01 -> post-pulse wait is 20 cycles. A same-cycle re-request of rs=1, data=0x42 while busy is not accepted, and output stays 0x01 until IDLE.
- Assert i_reset while EN is high during a data write -> EN=0 at the next edge, o_init_done=0, and the 0x38 init sequence restarts after 10 cycles.
- LCD_REQ_FIFO_EN: push 5 bytes back-to-back during init -> rdy drops after 4 accepted. After init, the 4 bytes appear on the bus in order.
- For every cycle, check: EN never high while state≠EN_HI, and o_lcd_rw is always 0.

Source files
------------

// File: rtl/lcd_controller.sv
// HD44780 bus sequencer for a 16x2 character LCD: power-on init, then timed write transfers.
// Optional LCD_REQ_FIFO_EN places a 4-entry request FIFO in front of the sequencer.
module lcd_controller #(
  parameter int T_PWRON = 750000,
  parameter int T_SETUP = 4,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLEAR = 82000,
  parameter int CNT_W   = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_vld,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_req_rdy,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    EN_HI,
    HOLD,
    EXEC_WAIT,
    IDLE
  } state_t;

  localparam logic [CNT_W-1:0] PWRON_LAST = CNT_W'(T_PWRON - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] EXEC_LAST  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(T_CLEAR - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       idx;
  logic             req_rs;
  logic [7:0]       req_data;
  logic             accept;
  logic             src_rs;
  logic [7:0]       src_data;
  logic             long_cmd;
  logic [CNT_W-1:0] wait_last;
  logic             exec_done;

  function automatic logic [7:0] init_rom(input logic [1:0] i);
    case (i)
      2'd0:    init_rom = 8'h38;
      2'd1:    init_rom = 8'h0C;
      2'd2:    init_rom = 8'h01;
      default: init_rom = 8'h06;
    endcase
  endfunction

`ifdef LCD_REQ_FIFO_EN
  logic [8:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       fifo_full, fifo_empty, push;

  assign fifo_full  = (fifo_cnt == 3'd4);
  assign fifo_empty = (fifo_cnt == 3'd0);
  // lcd_on doubles as an out-of-reset flag so rdy reads 0 while reset is held
  assign o_req_rdy  = o_lcd_on & !fifo_full;
  assign push       = i_req_vld & o_req_rdy;
  assign accept     = (state == IDLE) & !fifo_empty;
  assign o_busy     = (state != IDLE) | !fifo_empty;
  assign {src_rs, src_data} = fifo_mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (push) fifo_mem[wr_ptr] <= {i_req_rs, i_req_data};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 2'd1;
      if (accept) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + 3'(push) - 3'(accept);
    end
  end
`else
  assign o_req_rdy = (state == IDLE);
  assign o_busy    = (state != IDLE);
  assign accept    = (state == IDLE) & i_req_vld;
  assign src_rs    = i_req_rs;
  assign src_data  = i_req_data;
`endif

  assign o_lcd_rw  = 1'b0;
  assign long_cmd  = !o_lcd_rs && (o_lcd_data == 8'h01 || o_lcd_data == 8'h02 ||
                                   o_lcd_data == 8'h03);
  assign wait_last = long_cmd ? CLEAR_LAST : EXEC_LAST;
  assign exec_done = (state == EXEC_WAIT) && (cnt == wait_last);

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    case (state)
      PWR_WAIT:  if (cnt == PWRON_LAST) state_d = INIT_LOAD; else cnt_d = cnt + CNT_W'(1);
      INIT_LOAD: state_d = SETUP;
      SETUP:     if (cnt == SETUP_LAST) state_d = EN_HI;     else cnt_d = cnt + CNT_W'(1);
      EN_HI:     if (cnt == EN_LAST)    state_d = HOLD;      else cnt_d = cnt + CNT_W'(1);
      HOLD:      if (cnt == HOLD_LAST)  state_d = EXEC_WAIT; else cnt_d = cnt + CNT_W'(1);
      EXEC_WAIT: begin
        if (exec_done) begin
          if (!o_init_done && idx != 2'd3) state_d = INIT_LOAD;
          else                             state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      IDLE:      if (accept) state_d = INIT_LOAD;
      default:   state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= PWR_WAIT;
      cnt         <= '0;
      idx         <= '0;
      o_init_done <= 1'b0;
      o_lcd_on    <= 1'b0;
      o_lcd_en    <= 1'b0;
      o_lcd_rs    <= 1'b0;
      o_lcd_data  <= '0;
      req_rs      <= 1'b0;
      req_data    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      o_lcd_on <= 1'b1;
      o_lcd_en <= (state_d == EN_HI);
      if (accept) begin
        req_rs   <= src_rs;
        req_data <= src_data;
      end
      // Software requests reuse INIT_LOAD, so SETUP is always entered from there
      if (state == INIT_LOAD) begin
        if (o_init_done) begin
          o_lcd_rs   <= req_rs;
          o_lcd_data <= req_data;
        end else begin
          o_lcd_rs   <= 1'b0;
          o_lcd_data <= init_rom(idx);
        end
      end
      if (exec_done && !o_init_done) begin
        if (idx == 2'd3) o_init_done <= 1'b1;
        else             idx         <= idx + 2'd1;
      end
    end
  end

endmodule
